wb_arbiter: RTL

- Write-back collector and arbiter that drives the architectural register file's write ports.
- Accepts results from NUM_SRC producers (ALU pipe, LSU, mul/div) over per-source valid/ready channels.
- Buffers each source in a small FIFO and grants up to WRITE_PORTS writes per cycle, round-robin.
- Exports a per-register pending-write vector that issue logic uses for hazard stalls.

---
 rtl/wb_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Write-back collector: per-source result FIFOs feeding WRITE_PORTS register-file
// write ports through a round-robin grant, plus a pending-write scoreboard vector.
module wb_arbiter #(
    parameter int NUM_SRC          = 3,
    parameter int AREG_WRITE_PORTS = 2,
    parameter int WRITE_PORTS      = AREG_WRITE_PORTS,
    parameter int FIFO_DEPTH       = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_SRC-1:0]                   src_valid,
    output logic [NUM_SRC-1:0]                   src_ready,
    input  logic [NUM_SRC-1:0][4:0]              src_addr,
    input  logic [NUM_SRC-1:0][63:0]             src_data,
    output logic [WRITE_PORTS-1:0][4:0]          wa,
    output logic [WRITE_PORTS-1:0]               wvalid,
    output logic [WRITE_PORTS-1:0][63:0]         wd,
    output logic [31:0]                          pending
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int RRW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [RRW:0] NSRC_W = (RRW+1)'(NUM_SRC);

    logic [NUM_SRC-1:0][FIFO_DEPTH-1:0][4:0]  addr_mem_q, addr_mem_d;
    logic [NUM_SRC-1:0][FIFO_DEPTH-1:0][63:0] data_mem_q, data_mem_d;
    logic [NUM_SRC-1:0][PW:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [RRW-1:0]                           rr_ptr_q, rr_ptr_d;
    logic                                     ready_en_q, ready_en_d;

    logic [NUM_SRC-1:0]       full_s, empty_s, push_s, pop_s;
    logic [NUM_SRC-1:0][4:0]  head_addr_s;
    logic [NUM_SRC-1:0][63:0] head_data_s;

    // FIFO status, handshake and head-of-queue selection.
    // ready_en_q keeps src_ready low through reset and for the first cycle after it.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            full_s[s]      = (wr_ptr_q[s][PW] != rd_ptr_q[s][PW]) &&
                             (wr_ptr_q[s][PW-1:0] == rd_ptr_q[s][PW-1:0]);
            empty_s[s]     = (wr_ptr_q[s] == rd_ptr_q[s]);
            src_ready[s]   = ready_en_q & ~full_s[s];
            push_s[s]      = src_valid[s] & src_ready[s] & (src_addr[s] != 5'd0);
            head_addr_s[s] = addr_mem_q[s][rd_ptr_q[s][PW-1:0]];
            head_data_s[s] = data_mem_q[s][rd_ptr_q[s][PW-1:0]];
        end
    end

    // Round-robin grant of FIFO heads onto write ports, skipping same-address heads.
    always_comb begin
        logic [RRW:0]   sum_v;
        logic [RRW-1:0] src_v;
        logic           conflict_v;
        logic           grant_v;
        logic           sel_v;
        int             port_v;
        wvalid     = '0;
        wa         = '0;
        wd         = '0;
        pop_s      = '0;
        rr_ptr_d   = rr_ptr_q;
        sum_v      = '0;
        src_v      = '0;
        conflict_v = 1'b0;
        grant_v    = 1'b0;
        sel_v      = 1'b0;
        port_v     = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sum_v      = {1'b0, rr_ptr_q} + (RRW+1)'(i);
            src_v      = (sum_v >= NSRC_W) ? RRW'(sum_v - NSRC_W) : RRW'(sum_v);
            conflict_v = 1'b0;
            for (int p = 0; p < WRITE_PORTS; p++) begin
                conflict_v = conflict_v | ((p < port_v) && (wa[p] == head_addr_s[src_v]));
            end
            grant_v = !empty_s[src_v] && !conflict_v && (port_v < WRITE_PORTS);
            for (int p = 0; p < WRITE_PORTS; p++) begin
                sel_v     = grant_v && (p == port_v);
                wvalid[p] = wvalid[p] | sel_v;
                wa[p]     = sel_v ? head_addr_s[src_v] : wa[p];
                wd[p]     = sel_v ? head_data_s[src_v] : wd[p];
            end
            for (int s = 0; s < NUM_SRC; s++) begin
                pop_s[s] = pop_s[s] | (grant_v && (src_v == RRW'(s)));
            end
            rr_ptr_d = !grant_v ? rr_ptr_d :
                       (src_v == RRW'(NUM_SRC-1)) ? '0 : src_v + RRW'(1);
            port_v   = port_v + (grant_v ? 1 : 0);
        end
    end

    // Pending-write vector over every occupied FIFO slot; register 0 never reports pending.
    always_comb begin
        logic [31:0]   pend_v;
        logic [PW:0]   occ_v;
        logic [PW-1:0] off_v;
        pend_v = '0;
        occ_v  = '0;
        off_v  = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            occ_v = wr_ptr_q[s] - rd_ptr_q[s];
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                off_v = PW'(k) - rd_ptr_q[s][PW-1:0];
                pend_v[addr_mem_q[s][k]] = pend_v[addr_mem_q[s][k]] | ({1'b0, off_v} < occ_v);
            end
        end
        pending = {pend_v[31:1], 1'b0};
    end

    // FIFO pointer and storage next-state.
    always_comb begin
        logic wsel_v;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        ready_en_d = 1'b1;
        wsel_v     = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            wr_ptr_d[s] = wr_ptr_q[s] + {{PW{1'b0}}, push_s[s]};
            rd_ptr_d[s] = rd_ptr_q[s] + {{PW{1'b0}}, pop_s[s]};
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                wsel_v           = push_s[s] && (wr_ptr_q[s][PW-1:0] == PW'(k));
                addr_mem_d[s][k] = wsel_v ? src_addr[s] : addr_mem_q[s][k];
                data_mem_d[s][k] = wsel_v ? src_data[s] : data_mem_q[s][k];
            end
        end
    end

    // State registers; reset discards every buffered result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_mem_q <= '0;
            data_mem_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rr_ptr_q   <= '0;
            ready_en_q <= 1'b0;
        end else begin
            addr_mem_q <= addr_mem_d;
            data_mem_q <= data_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rr_ptr_q   <= rr_ptr_d;
            ready_en_q <= ready_en_d;
        end
    end
endmodule
